// File: rtl/niosii_system_actuator_pio.sv
// Avalon-MM actuator output port: level register with set/clear aliases plus a
// shared hardware one-shot that holds selected lines for pulse_len clocks.
module niosii_system_actuator_pio #(
  parameter int DATA_WIDTH      = 4,
  parameter int PULSE_LEN_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  typedef enum logic {ST_IDLE, ST_PULSE} state_t;

  localparam logic [2:0] A_DATA     = 3'd0;
  localparam logic [2:0] A_PLEN     = 3'd1;
  localparam logic [2:0] A_IRQ_MASK = 3'd2;
  localparam logic [2:0] A_DONE     = 3'd3;
  localparam logic [2:0] A_OUTSET   = 3'd4;
  localparam logic [2:0] A_OUTCLR   = 3'd5;
  localparam logic [2:0] A_TRIG     = 3'd6;
  localparam logic [2:0] A_STATUS   = 3'd7;

  state_t                     r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0]      r_out_data;
  logic [PULSE_LEN_WIDTH-1:0] r_pulse_len;
  logic [DATA_WIDTH-1:0]      r_pulse_mask, w_pulse_mask_nxt;
  logic [PULSE_LEN_WIDTH-1:0] r_count, w_count_nxt;
  logic                       r_irq_mask;
  logic                       r_done;
  logic [31:0]                r_readdata;

  logic                       w_wr;
  logic                       w_trig_ok;
  logic                       w_done_set;
  logic [DATA_WIDTH-1:0]      w_wmask;
  logic [31:0]                w_rd_mux;
  logic                       w_unused;

  assign w_wr      = chipselect & ~write_n;
  assign w_wmask   = writedata[DATA_WIDTH-1:0];
  // A trigger only counts when it would actually drive something for >0 cycles.
  assign w_trig_ok = w_wr && (address == A_TRIG) &&
                     (r_pulse_len != '0) && (w_wmask != '0);
  assign w_unused  = &{1'b0, writedata};

  always_comb begin
    w_state_nxt      = r_state;
    w_pulse_mask_nxt = r_pulse_mask;
    w_count_nxt      = r_count;
    w_done_set       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_trig_ok) begin
          w_state_nxt      = ST_PULSE;
          w_pulse_mask_nxt = w_wmask;
          w_count_nxt      = r_pulse_len;
        end
      end
      ST_PULSE: begin
        // Retrigger beats the terminal cycle, so a running pulse never reports done early.
        if (w_trig_ok) begin
          w_pulse_mask_nxt = r_pulse_mask | w_wmask;
          w_count_nxt      = r_pulse_len;
        end else if (r_count == PULSE_LEN_WIDTH'(1)) begin
          w_state_nxt      = ST_IDLE;
          w_pulse_mask_nxt = '0;
          w_count_nxt      = '0;
          w_done_set       = 1'b1;
        end else begin
          w_count_nxt      = r_count - PULSE_LEN_WIDTH'(1);
        end
      end
      default: begin
        w_state_nxt      = ST_IDLE;
        w_pulse_mask_nxt = '0;
        w_count_nxt      = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_pulse_mask <= '0;
      r_count      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pulse_mask <= w_pulse_mask_nxt;
      r_count      <= w_count_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_data  <= '0;
      r_pulse_len <= '0;
      r_irq_mask  <= 1'b0;
    end else if (w_wr) begin
      case (address)
        A_DATA:     r_out_data  <= w_wmask;
        A_PLEN:     r_pulse_len <= writedata[PULSE_LEN_WIDTH-1:0];
        A_IRQ_MASK: r_irq_mask  <= writedata[0];
        A_OUTSET:   r_out_data  <= r_out_data | w_wmask;
        A_OUTCLR:   r_out_data  <= r_out_data & ~w_wmask;
        default: ;
      endcase
    end
  end

  // A completing pulse wins over a simultaneous DONE write so no event is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done <= 1'b0;
    end else if (w_done_set) begin
      r_done <= 1'b1;
    end else if (w_wr && (address == A_DONE)) begin
      r_done <= 1'b0;
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      A_DATA:     w_rd_mux = 32'(r_out_data);
      A_PLEN:     w_rd_mux = 32'(r_pulse_len);
      A_IRQ_MASK: w_rd_mux = {31'b0, r_irq_mask};
      A_DONE:     w_rd_mux = {31'b0, r_done};
      A_TRIG:     w_rd_mux = 32'(r_pulse_mask);
      A_STATUS:   w_rd_mux = (32'(r_count) << 16) | {31'b0, (r_state == ST_PULSE)};
      default:    w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rd_mux;
    end
  end

  assign readdata = r_readdata;
  assign out_port = r_out_data | r_pulse_mask;
  assign irq      = r_done & r_irq_mask;

endmodule

// File: tb/tb_niosii_system_actuator_pio.sv
// Bench for the actuator PIO: a time-based reference model predicts every
// cycle's outputs into a queue that a separate monitor pops and compares.
module tb_niosii_system_actuator_pio;

  localparam int DW  = 4;
  localparam int PLW = 16;
  localparam int QW  = 1 + DW + 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [DW-1:0] out_port;
  logic          irq;

  niosii_system_actuator_pio #(.DATA_WIDTH(DW), .PULSE_LEN_WIDTH(PLW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .irq        (irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard: {irq, out_port, readdata} expected after each edge
  logic [QW-1:0] exp_q[$];
  logic [QW-1:0] exp_e;
  int vectors     = 0;
  int miscompares = 0;

  // reference model: a pulse is described by the absolute cycle it ends at
  logic [DW-1:0]  m_out_data;
  logic [DW-1:0]  m_pulse_mask;
  logic [PLW-1:0] m_pulse_len;
  logic           m_irq_mask;
  logic           m_done;
  longint         m_cyc;
  longint         m_end;

  task automatic model_reset();
    m_out_data   = '0;
    m_pulse_mask = '0;
    m_pulse_len  = '0;
    m_irq_mask   = 1'b0;
    m_done       = 1'b0;
    m_cyc        = 0;
    m_end        = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    longint cnt;
    logic   busy;
    busy = (m_cyc < m_end);
    cnt  = busy ? (m_end - m_cyc) : 0;
    case (a)
      3'd0:    return 32'(m_out_data);
      3'd1:    return 32'(m_pulse_len);
      3'd2:    return {31'b0, m_irq_mask};
      3'd3:    return {31'b0, m_done};
      3'd6:    return 32'(m_pulse_mask);
      3'd7:    return (32'(cnt) << 16) | {31'b0, busy};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge(input logic w, input logic [2:0] a, input logic [31:0] d);
    logic [31:0]   rd;
    logic          busy_pre;
    logic          retrig;
    logic          done_ev;
    logic [DW-1:0] msk;
    msk      = d[DW-1:0];
    rd       = model_read(a);
    busy_pre = (m_cyc < m_end);
    retrig   = w && (a == 3'd6) && (m_pulse_len != 0) && (msk != 0);
    done_ev  = busy_pre && (m_end == m_cyc + 1) && !retrig;
    if (w) begin
      case (a)
        3'd0: m_out_data  = msk;
        3'd1: m_pulse_len = d[PLW-1:0];
        3'd2: m_irq_mask  = d[0];
        3'd3: m_done      = 1'b0;
        3'd4: m_out_data  = m_out_data | msk;
        3'd5: m_out_data  = m_out_data & ~msk;
        default: ;
      endcase
    end
    if (retrig) begin
      m_pulse_mask = busy_pre ? (m_pulse_mask | msk) : msk;
      m_end        = m_cyc + 1 + longint'(m_pulse_len);
    end
    if (done_ev) begin
      m_done       = 1'b1;
      m_pulse_mask = '0;
    end
    m_cyc = m_cyc + 1;
    exp_q.push_back({m_done & m_irq_mask, m_out_data | m_pulse_mask, rd});
  endtask

  // driver tasks
  task automatic step(input logic cs, input logic wr, input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = cs;
    write_n    = ~wr;
    address    = a;
    writedata  = d;
    model_edge(cs & wr, a, d);
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, a, d);
  endtask

  task automatic bus_rd(input logic [2:0] a);
    step(1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'($urandom_range(0, 7)), $urandom);
  endtask

  task automatic check_now(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    #1;
    check_now("rst_out_port", 32'(out_port), 32'h0);
    check_now("rst_irq", 32'(irq), 32'h0);
    check_now("rst_readdata", readdata, 32'h0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  // monitor
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      exp_e = exp_q.pop_front();
      vectors++;
      if (readdata !== exp_e[31:0]) begin
        miscompares++;
        $display("FAIL readdata: got %h expected %h at %0t", readdata, exp_e[31:0], $time);
      end
      if (out_port !== exp_e[32 +: DW]) begin
        miscompares++;
        $display("FAIL out_port: got %h expected %h at %0t", out_port, exp_e[32 +: DW], $time);
      end
      if (irq !== exp_e[QW-1]) begin
        miscompares++;
        $display("FAIL irq: got %b expected %b at %0t", irq, exp_e[QW-1], $time);
      end
    end
  end

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = 32'h0;
    model_reset();
    #1;
    check_now("init_out_port", 32'(out_port), 32'h0);
    check_now("init_irq", 32'(irq), 32'h0);
    check_now("init_readdata", readdata, 32'h0);
    #21 reset_n = 1'b1;

    // level control
    bus_wr(3'd0, 32'h5); bus_rd(3'd0); bus_rd(3'd0);
    bus_wr(3'd4, 32'h2); bus_wr(3'd5, 32'h4);
    bus_rd(3'd4); bus_rd(3'd5); bus_rd(3'd0);

    // one-shot, irq masked then unmasked, DONE clear
    bus_wr(3'd0, 32'h0); bus_wr(3'd1, 32'h3); bus_wr(3'd2, 32'h0);
    bus_wr(3'd6, 32'h8); idle(5); bus_rd(3'd3);
    bus_wr(3'd2, 32'h1); idle(1); bus_wr(3'd3, 32'h0); idle(1);

    // retrigger extends and merges
    bus_wr(3'd1, 32'h5); bus_wr(3'd6, 32'h1); idle(2);
    bus_wr(3'd6, 32'h2); idle(8); bus_rd(3'd3); bus_wr(3'd3, 32'h0);

    // boundaries
    bus_wr(3'd1, 32'h0); bus_wr(3'd6, 32'hF); bus_rd(3'd7); bus_rd(3'd3);
    bus_wr(3'd1, 32'h2); bus_wr(3'd6, 32'h0); bus_rd(3'd7);
    bus_wr(3'd6, 32'h1); idle(1); bus_wr(3'd3, 32'h0); bus_rd(3'd3);
    bus_wr(3'd3, 32'h0);
    bus_wr(3'd6, 32'h1); idle(1); bus_wr(3'd6, 32'h2); bus_rd(3'd7);
    idle(3); bus_wr(3'd3, 32'h0);

    // level/pulse overlap
    bus_wr(3'd0, 32'h1); bus_wr(3'd1, 32'h4); bus_wr(3'd6, 32'h1);
    bus_wr(3'd5, 32'h1); idle(5); bus_wr(3'd0, 32'h0);

    // reset mid-pulse
    bus_wr(3'd1, 32'd100); bus_wr(3'd6, 32'h1); idle(9);
    do_reset();
    bus_rd(3'd7); bus_rd(3'd3); bus_rd(3'd0);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic [2:0]  a;
      logic [31:0] d;
      a = 3'($urandom_range(0, 7));
      d = (a == 3'd1) ? 32'($urandom_range(0, 7)) : $urandom;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, d);
    end
    idle(2);

    repeat (2) @(posedge clk);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/niosii_system_actuator_pio.md
Name: niosII_system_actuator_pio

Overview:
Avalon-MM slave output port that drives DATA_WIDTH actuator lines (injector/ignition enables) from the Nios II, the output counterpart of the switch input PIO.
- Level control: a data register with atomic set and clear aliases.
- Hardware one-shot: a shared cycle-count timer asserts selected lines for exactly PULSE_LEN clocks.
- Completion reporting: a maskable done interrupt fires when the pulse ends.

Parameters:
DATA_WIDTH, 4, number of output lines (1..32).
PULSE_LEN_WIDTH, 16, width of pulse length register and down-counter.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset_n  input  1  reset, asynchronous assert, active-low.
address  input  3  register word address.
chipselect  input  1  slave select.
write_n  input  1  active-low write strobe, valid only with chipselect.
writedata  input  32  write data.
readdata  output  32  registered read data.
out_port  output  DATA_WIDTH  actuator lines.
irq  output  1  done interrupt, level.

Behaviour:
- Reset: one clock, asynchronous active-low reset (reset_n). On reset all state clears, including mid-pulse, with no done event: out_data=0, pulse_len=0, pulse_mask=0, count=0, state=IDLE, done=0, irq_mask=0, readdata=0, out_port=0, irq=0.
- Write strobe: wr = chipselect & ~write_n; registers update on the edge after the strobe.
- Register map (unused high bits read 0, writes ignore them):
  - 0 DATA: R/W out_data[DATA_WIDTH-1:0].
  - 1 PULSE_LEN: R/W pulse_len[PULSE_LEN_WIDTH-1:0].
  - 2 IRQ_MASK: R/W bit0.
  - 3 DONE: read bit0 = done; any write clears done.
  - 4 OUTSET: write out_data |= writedata; reads 0.
  - 5 OUTCLEAR: write out_data &= ~writedata; reads 0.
  - 6 PULSE_TRIG: write starts or extends a pulse on bits writedata[DATA_WIDTH-1:0]; reads current pulse_mask.
  - 7 STATUS: bit0 busy (state==PULSE), bits[PULSE_LEN_WIDTH+15:16] = count.
- Read: readdata is registered from the address-selected mux every clock regardless of chipselect. Read latency 1 cycle.
- out_port = out_data | pulse_mask. Combinational from registers, so a change appears the cycle after the write edge.
- irq = done & irq_mask.
- FSM, IDLE:
  - PULSE_TRIG with pulse_len!=0 and nonzero mask → PULSE; pulse_mask=mask; count=pulse_len.
  - pulse_len==0 or mask==0 → trigger ignored, no done.
- FSM, PULSE:
  - count decrements each cycle.
  - On the edge where count==1: state→IDLE, pulse_mask→0, count→0, done→1.
  - Pulse lines are therefore high for exactly pulse_len clock cycles.
- Retrigger in PULSE (pulse_len!=0): pulse_mask |= mask; count reloads to pulse_len. No done for the first pulse. A retrigger on the terminal (count==1) cycle wins: remain in PULSE, no done.
- PULSE_TRIG in PULSE with pulse_len==0: ignored.
- PULSE_LEN written during PULSE: the running count is unaffected; the new value applies to the next trigger.
- Done set and DONE write on the same edge: set wins, done=1, so an event is never lost.
- OUTCLEAR does not affect pulse_mask. A line held by the pulse stays high until the pulse ends.
- Counter width: count is PULSE_LEN_WIDTH bits and never wraps, since the 1→IDLE transition precedes 0.

Test Plan:
- Reset: hold reset_n=0 mid-pulse (PULSE_LEN=100, trig 0x1, reset at cycle 10) → out_port=0, irq=0, readdata=0 immediately; STATUS=0 after release; DONE reads 0.
- Level control:
  - write DATA=0x5, read addr0 → 0x5 one cycle after address.
  - OUTSET 0x2 → out_port=0x7.
  - OUTCLEAR 0x4 → 0x3.
  - read addr4/5 → 0.
- One-shot: PULSE_LEN=3, DATA=0, trig 0x8 → out_port[3]=1 for exactly 3 cycles starting the cycle after the write edge. Then done=1; irq=1 only if IRQ_MASK=1; DONE write → irq=0.
- Retrigger: PULSE_LEN=5, trig 0x1, after 3 cycles trig 0x2 → bit0 high 8 cycles, bit1 high 5 cycles, ending together; one done event only.
- Boundaries:
  - PULSE_LEN=0 trig 0xF → no output change, busy=0, done=0.
  - trig mask 0 → ignored.
  - DONE write on the terminal cycle → done=1.
  - retrigger on the count==1 cycle → busy stays 1.
- Overlap: DATA=0x1 with pulse on 0x1 len 4, then OUTCLEAR 0x1 at cycle 1 → out_port[0] stays 1 until the pulse ends, then 0.
